// File: rtl/spi_shift_reg.sv
// Handshaked N-bit SPI shift engine: loads a word, shifts it out MSB/LSB-first per shift_en tick, captures s_in into rx_data.
// Optional SPI_SHIFT_REG_LOOPBACK_EN adds an lpbk input that rotates s_out back into the register.
module spi_shift_reg #(
  parameter int N         = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         ld_valid,
  output logic         ld_ready,
  input  logic [N-1:0] ld_data,
  input  logic         shift_en,
  input  logic         s_in,
`ifdef SPI_SHIFT_REG_LOOPBACK_EN
  input  logic         lpbk,
`endif
  output logic         s_out,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] rx_data
);

  localparam int CNT_W = (N > 2) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [N-1:0]     sreg;
  logic [N-1:0]     sreg_nxt;
  logic             tx_bit;
  logic             in_bit;

  function automatic logic [N-1:0] shift_in(input logic [N-1:0] v, input logic b);
    if (LSB_FIRST)
      return {b, v[N-1:1]};
    else
      return {v[N-2:0], b};
  endfunction

  always_comb begin
    tx_bit = LSB_FIRST ? sreg[0] : sreg[N-1];
    s_out  = (state == ST_SHIFT) && tx_bit;
`ifdef SPI_SHIFT_REG_LOOPBACK_EN
    in_bit = lpbk ? tx_bit : s_in;
`else
    in_bit = s_in;
`endif
    sreg_nxt = shift_in(sreg, in_bit);
  end

  // Control and status are registered alongside the state so they change on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      sreg     <= '0;
      rx_data  <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      ld_ready <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ld_valid) begin
            sreg     <= ld_data;
            bit_cnt  <= '0;
            state    <= ST_SHIFT;
            ld_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (shift_en) begin
            sreg <= sreg_nxt;
            if (bit_cnt == LAST_CNT) begin
              rx_data <= sreg_nxt;
              bit_cnt <= '0;
              state   <= ST_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          done     <= 1'b0;
          ld_ready <= 1'b1;
        end
        default: begin
          state    <= ST_IDLE;
          bit_cnt  <= '0;
          done     <= 1'b0;
          busy     <= 1'b0;
          ld_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
